// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing constants and helpers
package vga_timing_pkg;

  localparam int COUNT_W = 10;
  typedef logic [COUNT_W-1:0] count_t;

  // Default 640x480 timing on a 100 MHz system clock
  localparam int VGA_CLK_DIV     = 4;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC_END  = 96;
  localparam int VGA_H_ACT_START = 144;
  localparam int VGA_H_ACT_END   = 784;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC_END  = 2;
  localparam int VGA_V_ACT_START = 35;
  localparam int VGA_V_ACT_END   = 515;

  localparam int CLKS_PER_LINE  = VGA_CLK_DIV * VGA_H_TOTAL;
  localparam int CLKS_PER_FRAME = CLKS_PER_LINE * VGA_V_TOTAL;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic bright;
  } vga_decode_t;

  // Half-open interval test: lo inclusive, hi exclusive
  function automatic logic in_range(input count_t c, input count_t lo, input count_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - registered one-clk enable strobe every CLK_DIV clocks
module clk_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic en_out
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;

  assign div_last = (div_cnt == DIV_LAST);

  // Strobe lands on the clk after the counter shows its last value
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      en_out  <= 1'b0;
    end else begin
      en_out  <= div_last;
      div_cnt <= div_last ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA pixel/line counters with sync, window and frame decode
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = vga_timing_pkg::VGA_CLK_DIV,
  parameter int H_TOTAL     = vga_timing_pkg::VGA_H_TOTAL,
  parameter int H_SYNC_END  = vga_timing_pkg::VGA_H_SYNC_END,
  parameter int H_ACT_START = vga_timing_pkg::VGA_H_ACT_START,
  parameter int H_ACT_END   = vga_timing_pkg::VGA_H_ACT_END,
  parameter int V_TOTAL     = vga_timing_pkg::VGA_V_TOTAL,
  parameter int V_SYNC_END  = vga_timing_pkg::VGA_V_SYNC_END,
  parameter int V_ACT_START = vga_timing_pkg::VGA_V_ACT_START,
  parameter int V_ACT_END   = vga_timing_pkg::VGA_V_ACT_END
) (
  input  logic   clk,
  input  logic   rst,
  output count_t hCount,
  output count_t vCount,
  output logic   bright,
  output logic   hSync,
  output logic   vSync,
  output logic   pix_en,
  output logic   frame_tick
);

  localparam count_t H_LAST  = count_t'(H_TOTAL - 1);
  localparam count_t V_LAST  = count_t'(V_TOTAL - 1);
  localparam count_t H_SE    = count_t'(H_SYNC_END);
  localparam count_t V_SE    = count_t'(V_SYNC_END);
  localparam count_t H_AS    = count_t'(H_ACT_START);
  localparam count_t H_AE    = count_t'(H_ACT_END);
  localparam count_t V_AS    = count_t'(V_ACT_START);
  localparam count_t V_AE    = count_t'(V_ACT_END);
  localparam count_t V_FTICK = count_t'(V_ACT_END - 1);

  logic        h_wrap;
  logic        v_wrap;
  vga_decode_t dec;

  clk_en_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .en_out(pix_en)
  );

  assign h_wrap = (hCount == H_LAST);
  assign v_wrap = (vCount == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        hCount <= '0;
        vCount <= v_wrap ? '0 : vCount + 1'b1;
      end else begin
        hCount <= hCount + 1'b1;
      end
    end
  end

  // Pure decode of the registered counters, so it moves on the same edge they do
  always_comb begin
    dec        = '0;
    dec.hsync  = (hCount >= H_SE);
    dec.vsync  = (vCount >= V_SE);
    dec.bright = in_range(hCount, H_AS, H_AE) && in_range(vCount, V_AS, V_AE);
  end

  assign hSync      = dec.hsync;
  assign vSync      = dec.vsync;
  assign bright     = dec.bright;
  assign frame_tick = pix_en && h_wrap && (vCount == V_FTICK);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  // Scaled-down timing so whole frames fit in a short run
  localparam int S_HT = 20, S_HSE = 3, S_HAS = 5, S_HAE = 17;
  localparam int S_VT = 12, S_VSE = 2, S_VAS = 3, S_VAE = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] h_s, v_s, h_d, v_d;
  logic       br_s, hs_s, vs_s, pe_s, ft_s;
  logic       br_d, hs_d, vs_d, pe_d, ft_d;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(4), .H_TOTAL(S_HT), .H_SYNC_END(S_HSE), .H_ACT_START(S_HAS), .H_ACT_END(S_HAE),
    .V_TOTAL(S_VT), .V_SYNC_END(S_VSE), .V_ACT_START(S_VAS), .V_ACT_END(S_VAE)
  ) dut (
    .clk(clk), .rst(rst), .hCount(h_s), .vCount(v_s), .bright(br_s),
    .hSync(hs_s), .vSync(vs_s), .pix_en(pe_s), .frame_tick(ft_s)
  );

  vga_timing_gen dut_def (
    .clk(clk), .rst(rst), .hCount(h_d), .vCount(v_d), .bright(br_d),
    .hSync(hs_d), .vSync(vs_d), .pix_en(pe_d), .frame_tick(ft_d)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int h, v, hs, vs, br, pe, ft;
  } exp_t;

  // k = clocks since reset release; pixel index advances on the edge after each strobe
  function automatic exp_t model(input int k, input bit full);
    exp_t e;
    int ht, hse, has, hae, vt, vse, vas, vae, p;
    if (full) begin
      ht = 800; hse = 96; has = 144; hae = 784; vt = 525; vse = 2; vas = 35; vae = 515;
    end else begin
      ht = S_HT; hse = S_HSE; has = S_HAS; hae = S_HAE;
      vt = S_VT; vse = S_VSE; vas = S_VAS; vae = S_VAE;
    end
    p    = (k == 0) ? 0 : (k - 1) / 4;
    e.h  = p % ht;
    e.v  = (p / ht) % vt;
    e.pe = (k > 0 && (k % 4) == 0) ? 1 : 0;
    e.hs = (e.h >= hse) ? 1 : 0;
    e.vs = (e.v >= vse) ? 1 : 0;
    e.br = (e.h >= has && e.h < hae && e.v >= vas && e.v < vae) ? 1 : 0;
    e.ft = (e.pe == 1 && e.h == ht - 1 && e.v == vae - 1) ? 1 : 0;
    return e;
  endfunction

  // Window corners for the scaled timing, worked out by hand
  int win_h[5] = '{4, 5, 16, 17, 5};
  int win_v[5] = '{3, 3, 9, 9, 10};
  int win_b[5] = '{0, 1, 1, 0, 0};

  int k_clk = 0;
  bit agg_on = 1'b0;
  int n_br = 0, n_vs = 0, n_hs = 0, n_ft = 0, n_ft_bad = 0, n_hs_d = 0;

  task automatic tick_check();
    exp_t es, ed;
    @(posedge clk);
    if (rst) k_clk = 0;
    else k_clk++;
    @(negedge clk);
    es = model(k_clk, 1'b0);
    ed = model(k_clk, 1'b1);
    check("s_h", h_s, es.h);   check("s_v", v_s, es.v);
    check("s_hs", hs_s, es.hs); check("s_vs", vs_s, es.vs);
    check("s_br", br_s, es.br); check("s_pe", pe_s, es.pe);
    check("s_ft", ft_s, es.ft);
    check("d_h", h_d, ed.h);   check("d_v", v_d, ed.v);
    check("d_hs", hs_d, ed.hs); check("d_vs", vs_d, ed.vs);
    check("d_br", br_d, ed.br); check("d_pe", pe_d, ed.pe);
    check("d_ft", ft_d, ed.ft);
    for (int i = 0; i < 5; i++)
      if (es.h == win_h[i] && es.v == win_v[i]) check("s_win", br_s, win_b[i]);
    if (agg_on) begin
      if (k_clk >= 1 && k_clk <= 960) begin
        if (pe_s && br_s) n_br++;
        if (pe_s && !vs_s) n_vs++;
        if (pe_s && !hs_s) n_hs++;
        if (ft_s) n_ft++;
        if (ft_s && !pe_s) n_ft_bad++;
      end
      if (k_clk >= 1 && k_clk <= 3200 && pe_d && !hs_d) n_hs_d++;
      if (k_clk == 3200) check("d_h_last", h_d, 799);
      if (k_clk == 3201) begin
        check("d_h_wrap", h_d, 0);
        check("d_v_step", v_d, 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick_check();
    rst = 1'b0;

    agg_on = 1'b1;
    repeat (3300) tick_check();
    agg_on = 1'b0;
    check("s_bright_cnt", n_br, 84);
    check("s_vsync_low", n_vs, 40);
    check("s_hsync_low", n_hs, 36);
    check("s_ftick_cnt", n_ft, 1);
    check("s_ftick_nopix", n_ft_bad, 0);
    check("d_hsync_low", n_hs_d, 96);

    // Mid-frame reset with divider at 2, pixel (10, 6)
    rst = 1'b1; tick_check(); rst = 1'b0;
    repeat (522) tick_check();
    check("mid_pre_h", h_s, 10);
    check("mid_pre_v", v_s, 6);
    rst = 1'b1; tick_check(); rst = 1'b0;
    check("mid_h", h_s, 0);
    check("mid_v", v_s, 0);
    check("mid_pe", pe_s, 0);
    check("mid_ft", ft_s, 0);
    repeat (3) tick_check();
    check("mid_pe3", pe_s, 0);
    tick_check();
    check("mid_pe4", pe_s, 1);

    // Reset on the edge that would raise frame_tick
    rst = 1'b1; tick_check(); rst = 1'b0;
    repeat (799) tick_check();
    check("ft_pre_h", h_s, 19);
    check("ft_pre_v", v_s, 9);
    check("ft_pre_ft", ft_s, 0);
    rst = 1'b1; tick_check(); rst = 1'b0;
    check("ft_rst_ft", ft_s, 0);
    check("ft_rst_h", h_s, 0);
    check("ft_rst_v", v_s, 0);
    repeat (8) tick_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel; 100 MHz clk gives a 25 MHz pixel rate.
REQ-002 Parameter H_TOTAL, default 800: pixel periods per line.
REQ-003 Parameter H_SYNC_END, default 96: hSync is low for hCount < H_SYNC_END.
REQ-004 Parameter H_ACT_START / H_ACT_END, default 144 / 784: horizontal visible window, start inclusive, end exclusive.
REQ-005 Parameter V_TOTAL, default 525: lines per frame.
REQ-006 Parameter V_SYNC_END, default 2: vSync is low for vCount < V_SYNC_END.
REQ-007 Parameter V_ACT_START / V_ACT_END, default 35 / 515: vertical visible window, start inclusive, end exclusive.
REQ-008 clk  input  1  system clock; the only clock; all state changes on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 hCount  output  10  current pixel column, 0..H_TOTAL-1.
REQ-011 vCount  output  10  current line, 0..V_TOTAL-1.
REQ-012 bright  output  1  high when (hCount, vCount) is inside the visible window.
REQ-013 hSync  output  1  horizontal sync, active low.
REQ-014 vSync  output  1  vertical sync, active low.
REQ-015 pix_en  output  1  one-clk strobe at the pixel rate.
REQ-016 frame_tick  output  1  one-clk strobe once per frame; used as the game-logic update enable.

Function
REQ-017 A divider counter (0..CLK_DIV-1) increments every clk and wraps CLK_DIV-1 -> 0.
REQ-018 pix_en is registered and high for exactly the one clk that follows the divider value CLK_DIV-1: on the CLK_DIV-th clk after reset release, then every CLK_DIV clks.
REQ-019 hCount and vCount change only on a clk edge where pix_en is high.
REQ-020 On such an edge, hCount increments, and wraps H_TOTAL-1 -> 0.
REQ-021 vCount increments only when hCount wraps, and wraps V_TOTAL-1 -> 0 on the same edge.
REQ-022 hSync, vSync and bright are combinational decodes of the current hCount/vCount, with zero latency relative to the counters.
REQ-023 bright = (H_ACT_START <= hCount < H_ACT_END) AND (V_ACT_START <= vCount < V_ACT_END).
REQ-024 frame_tick is high for exactly one clk: the clk on which pix_en is high with hCount = H_TOTAL-1 and vCount = V_ACT_END-1 (last pixel of the last visible line).
REQ-025 frame_tick is never high outside a pix_en cycle and never high twice in one frame.
REQ-026 Counter widths are 10 bits; parameter values above 1023 are illegal and are not checked.
REQ-027 No output glitches across the counter wraps; the decode stays consistent on the wrap edge.

Reset
REQ-028 While rst is high at a clk edge, the divider, hCount and vCount become 0, and pix_en and frame_tick become 0.
REQ-029 Values of the decoded outputs during reset: hSync = 0, vSync = 0, bright = 0.
REQ-030 Reset asserted mid-frame takes effect on the next clk edge regardless of divider phase.
REQ-031 After reset, counting restarts from divider 0, so pix_en timing follows REQ-018.
REQ-032 rst has priority over pix_en on the same edge.

Structure
REQ-033 Timing constants (the defaults above and the derived CLKS_PER_LINE = 3200 and CLKS_PER_FRAME = 1_680_000) live in shared package vga_timing_pkg; downstream drawing logic uses the same constants.
REQ-034 The pixel-rate divider is a single sub-module, clk_en_div (clk, rst, en_out), parameterised by CLK_DIV.
REQ-035 The counters and the decode are in vga_timing_gen itself.

Verification
REQ-036 Reset release: hold rst 3 clks, release -> pix_en low for 3 clks, first high on clk 4, then every 4th clk; hCount = 0 until the first pix_en edge.
REQ-037 Line timing: run 3200 clks -> hCount goes 0..799 and back to 0; vCount 0 -> 1 exactly on the wrap; hSync low for exactly 96 pix_en periods per line.
REQ-038 Frame timing: run 1,680,000 clks -> vCount wraps 524 -> 0; vSync low for 2 lines; bright high on exactly 307,200 pix_en cycles; frame_tick high exactly once, at hCount = 799, vCount = 514.
REQ-039 Window edges: check bright = 0 at (143, 35), 1 at (144, 35), 1 at (783, 514), 0 at (784, 514) and 0 at (144, 515).
REQ-040 Mid-frame reset: assert rst for 1 clk at hCount = 400, vCount = 200 with divider = 2 -> next clk hCount = 0, vCount = 0, pix_en = 0, frame_tick = 0; pix_en next high 4 clks after release.
REQ-041 Reset on a pix_en edge: assert rst on the edge where frame_tick would fire -> frame_tick stays 0 and the counters are 0.
